// File: rtl/serial_adder_2bit_seq_if.sv
// Start/done operand and result bus for the 2-bit-per-cycle serial adder.
// With SUB_MODE_EN defined the bus also carries the `sub` request bit.
interface serial_adder_2bit_seq_if #(
  parameter int WIDTH = 8
);
  // Handshake: the slave accepts start only in IDLE. a/b/cin/sub are captured on
  // that edge. done pulses once when result/cout are valid. busy is high while adding.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

`ifdef SUB_MODE_EN
  modport master (output start, a, b, cin, sub, input busy, done, result, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, result, cout);
`else
  modport master (output start, a, b, cin, input busy, done, result, cout);
  modport slave  (input start, a, b, cin, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_adder_2bit_seq.sv
// Serial adder: WIDTH-bit operands summed 2 bits per clock, LSB first, carry registered
// between slices. Defining SUB_MODE_EN adds a `sub` input that computes a - b.
module serial_adder_2bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  serial_adder_2bit_seq_if.slave    bus,
  output logic [1:0]                dbg_state
);

  localparam int SLICES = WIDTH / 2;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  generate
    if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
      $error("serial_adder_2bit_seq: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sub_in;
  logic             s0, c0, s1, c1;
  logic [WIDTH+1:0] shifted;

`ifdef SUB_MODE_EN
  assign sub_in = bus.sub;
`else
  assign sub_in = 1'b0;
`endif

  // Two-bit ripple slice: bit0 carry feeds bit1.
  assign s0 = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign c0 = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  assign s1 = a_sh_q[1] ^ b_sh_q[1] ^ c0;
  assign c1 = (a_sh_q[1] & b_sh_q[1]) | (c0 & (a_sh_q[1] ^ b_sh_q[1]));
  assign shifted = {s1, s0, result_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = ADD;
          a_sh_d   = bus.a;
          b_sh_d   = sub_in ? ~bus.b : bus.b;
          carry_d  = sub_in ? 1'b1 : bus.cin;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ADD: begin
        // New sum bits enter at the MSB end so the LSB slice lands at bit 0 last.
        result_d = shifted[WIDTH+1:2];
        a_sh_d   = a_sh_q >> 2;
        b_sh_d   = b_sh_q >> 2;
        carry_d  = c1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = c1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_adder_2bit_seq.sv
// Bench for serial_adder_2bit_seq: directed vectors, expected {cout,result} queued by the
// driver and checked by a done-triggered monitor. Define SUB_MODE_EN to cover subtraction.
module tb_serial_adder_2bit_seq;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_adder_2bit_seq_if #(.WIDTH(W)) bus_if ();

  serial_adder_2bit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus_if.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("sum", {23'd0, bus_if.cout, bus_if.result}, {23'd0, e});
      end
    end
  end

  // driver: one start pulse, optional ignored start during ADD, latency/busy checks
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic [W:0] exp, input logic inject);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    @(negedge clk);
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
`ifdef SUB_MODE_EN
    bus_if.sub   = sub;
`endif
    bus_if.start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus_if.start = 1'b0;
    for (int k = 1; k <= 12 && done_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (inject && k == 2) begin
        bus_if.a     = 8'h01;
        bus_if.b     = 8'h01;
        bus_if.start = 1'b1;
      end else if (inject && k == 3) begin
        bus_if.start = 1'b0;
      end
      if (bus_if.busy) busy_n++;
      if (bus_if.done) done_at = k;
    end
    check("busy_cycles", busy_n, 4);
    check("done_latency", done_at, 5);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;
`ifdef SUB_MODE_EN
    bus_if.sub   = 1'b0;
`endif

    // 1. reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_result", bus_if.result, 8'h00);
    check("rst_cout", bus_if.cout, 0);
    check("rst_state", dbg_state, 2'd0);
    repeat (3) @(negedge clk);

    // 2. FF + 01
    run_add(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0);
    @(negedge clk);

    // 3. 3C + 5A + 1, with a start during ADD that must be ignored
    run_add(8'h3C, 8'h5A, 1'b1, 1'b0, 9'h097, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_result", bus_if.result, 8'h97);
    check("hold_cout", bus_if.cout, 0);
    check("idle_after_ignore", dbg_state, 2'd0);

    // 4. reset in the second ADD cycle
    @(negedge clk);
    bus_if.a     = 8'hAA;
    bus_if.b     = 8'h55;
    bus_if.cin   = 1'b0;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_busy", bus_if.busy, 0);
    check("midrst_done", bus_if.done, 0);
    check("midrst_result", bus_if.result, 8'h00);
    check("midrst_cout", bus_if.cout, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // 5. start held high 20 cycles: accepts every 6 cycles
    begin
      int done_t[$];
      bus_if.a   = 8'h10;
      bus_if.b   = 8'h20;
      bus_if.cin = 1'b0;
      repeat (4) exp_q.push_back(9'h030);
      for (int i = 0; i < 30; i++) begin
        if (i > 0) @(negedge clk);
        bus_if.start = (i < 20);
        if (bus_if.done) done_t.push_back(i);
      end
      check("burst_done_count", done_t.size(), 4);
      for (int j = 1; j < done_t.size(); j++)
        check("burst_period", done_t[j] - done_t[j-1], 6);
    end
    @(negedge clk);

`ifdef SUB_MODE_EN
    // 6. subtraction
    run_add(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 1'b0);
    @(negedge clk);
    run_add(8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF, 1'b0);
    @(negedge clk);
    run_add(8'h12, 8'h34, 1'b1, 1'b0, 9'h047, 1'b0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
